// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: FSM states, latched event kind,
// interrupt cause codes and the trap_info layout.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_EXC  = 2'd1,
        EV_MRET = 2'd2,
        EV_IRQ  = 2'd3
    } trap_event_e;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    typedef struct packed {
        logic       is_irq;
        logic [3:0] code;
    } trap_info_t;

    // Fixed priority over enabled pending lines: external > software > timer.
    function automatic logic [3:0] irq_cause(input logic [2:0] pend);
        if (pend[0])      irq_cause = CAUSE_MEI;
        else if (pend[1]) irq_cause = CAUSE_MSI;
        else              irq_cause = CAUSE_MTI;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of every non-clock signal between the pipeline/CSR side and trap_ctrl.
// The pipeline side drives requests and CSR values; the controller drives the rest.
interface trap_ctrl_if;
    logic [2:0]  irq_raw;
    logic        ctrl_mie;
    logic [2:0]  ctrl_mxie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic [31:0] irq_pc;
    logic        req_ready;
    logic        drain_req;
    logic        drain_ack;
    logic [2:0]  ctrl_mxip;
    logic        ctrl_trap;
    logic        ctrl_mret;
    logic [31:0] trap_pc;
    logic [4:0]  trap_info;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output irq_raw, ctrl_mie, ctrl_mxie, mtvec, mepc, exc_valid, exc_code,
               exc_pc, mret_valid, irq_pc, drain_ack, redirect_ready,
        input  req_ready, drain_req, ctrl_mxip, ctrl_trap, ctrl_mret, trap_pc,
               trap_info, redirect_valid, redirect_pc
    );

    modport slave (
        input  irq_raw, ctrl_mie, ctrl_mxie, mtvec, mepc, exc_valid, exc_code,
               exc_pc, mret_valid, irq_pc, drain_ack, redirect_ready,
        output req_ready, drain_req, ctrl_mxip, ctrl_trap, ctrl_mret, trap_pc,
               trap_info, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for the asynchronous interrupt lines, cleared by
// the asynchronous active-low reset.
module irq_sync #(
    parameter int STAGES = 2,
    parameter int W      = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates exceptions, mret and interrupts, drains the
// pipeline, commits the trap and hands the redirect target to fetch.
// Define TRAP_CTRL_VECTORED_EN to honour mtvec vectored mode for interrupts.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic [2:0]  irq_raw,
    input  logic        ctrl_mie,
    input  logic [2:0]  ctrl_mxie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        mret_valid,
    input  logic [31:0] irq_pc,
    output logic        req_ready,
    output logic        drain_req,
    input  logic        drain_ack,
    output logic [2:0]  ctrl_mxip,
    output logic        ctrl_trap,
    output logic        ctrl_mret,
    output logic [31:0] trap_pc,
    output trap_info_t  trap_info,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output trap_state_e dbg_state_o
);

    // Handshakes: an exc/mret request is taken on a rising edge where it is
    // valid and req_ready is 1; drain completes on the first edge with
    // drain_ack=1 while drain_req=1; redirect completes on the first edge with
    // redirect_ready=1 while redirect_valid=1, and redirect_pc is stable until then.

    trap_state_e state_q, state_d;
    trap_event_e kind_q, kind_d;
    logic [3:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        ready_q, ready_d;
    logic        irq_pending;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    irq_sync #(
        .STAGES(SYNC_STAGES),
        .W     (3)
    ) u_irq_sync (
        .clk  (ctrl_clk),
        .rst_n(ctrl_reset_n),
        .d_i  (irq_raw),
        .q_o  (ctrl_mxip)
    );

    assign irq_pending = ctrl_mie & (|(ctrl_mxip & ctrl_mxie));
    assign trap_base   = {mtvec[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    always_comb begin
        trap_target = trap_base;
        if (kind_q == EV_IRQ && mtvec[1:0] == 2'b01)
            trap_target = trap_base + {26'd0, code_q, 2'b00};
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec[1:0];
    assign trap_target       = trap_base;
`endif

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= EV_NONE;
            code_q     <= '0;
            pc_q       <= '0;
            redir_pc_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            code_q     <= code_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            ready_q    <= ready_d;
        end
    end

    // ready_q mirrors "next state is IDLE" so req_ready stays 0 while reset
    // is held and during the first cycle after release.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        code_d     = code_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (ready_q) begin
                    if (exc_valid) begin
                        kind_d  = EV_EXC;
                        code_d  = exc_code;
                        pc_d    = exc_pc;
                        state_d = ST_DRAIN;
                    end else if (mret_valid) begin
                        kind_d  = EV_MRET;
                        code_d  = '0;
                        pc_d    = '0;
                        state_d = ST_DRAIN;
                    end else if (irq_pending) begin
                        kind_d  = EV_IRQ;
                        code_d  = irq_cause(ctrl_mxip & ctrl_mxie);
                        pc_d    = irq_pc;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_ack) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                redir_pc_d = (kind_q == EV_MRET) ? mepc : trap_target;
                state_d    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    assign req_ready      = ready_q;
    assign drain_req      = (state_q == ST_DRAIN);
    assign ctrl_trap      = (state_q == ST_COMMIT);
    assign ctrl_mret      = (state_q == ST_COMMIT) && (kind_q == EV_MRET);
    assign trap_pc        = (state_q == ST_COMMIT) ? pc_q : 32'd0;
    assign trap_info      = (state_q == ST_COMMIT) ?
                            trap_info_t'{is_irq: (kind_q == EV_IRQ), code: code_q} :
                            trap_info_t'(5'd0);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redir_pc_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, interrupt, mret, priority,
// vectored target and mid-drain reset scenarios.
module tb_trap_ctrl;
    import trap_pkg::*;

    logic        clk;
    logic        rst_n;
    trap_state_e dbg_state;
    int          checks;
    int          passes;

    trap_ctrl_if bus ();

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    trap_ctrl #(.SYNC_STAGES(2)) dut (
        .ctrl_clk      (clk),
        .ctrl_reset_n  (rst_n),
        .irq_raw       (bus.irq_raw),
        .ctrl_mie      (bus.ctrl_mie),
        .ctrl_mxie     (bus.ctrl_mxie),
        .mtvec         (bus.mtvec),
        .mepc          (bus.mepc),
        .exc_valid     (bus.exc_valid),
        .exc_code      (bus.exc_code),
        .exc_pc        (bus.exc_pc),
        .mret_valid    (bus.mret_valid),
        .irq_pc        (bus.irq_pc),
        .req_ready     (bus.req_ready),
        .drain_req     (bus.drain_req),
        .drain_ack     (bus.drain_ack),
        .ctrl_mxip     (bus.ctrl_mxip),
        .ctrl_trap     (bus.ctrl_trap),
        .ctrl_mret     (bus.ctrl_mret),
        .trap_pc       (bus.trap_pc),
        .trap_info     (bus.trap_info),
        .redirect_valid(bus.redirect_valid),
        .redirect_pc   (bus.redirect_pc),
        .redirect_ready(bus.redirect_ready),
        .dbg_state_o   (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.irq_raw = '0; bus.ctrl_mie = 1'b0; bus.ctrl_mxie = '0;
        bus.mtvec = 32'h800; bus.mepc = '0; bus.exc_valid = 1'b0;
        bus.exc_code = '0; bus.exc_pc = '0; bus.mret_valid = 1'b0;
        bus.irq_pc = '0; bus.drain_ack = 1'b0; bus.redirect_ready = 1'b0;
        #3;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready: got %0b expected 0", bus.req_ready); else passes++;
        checks++; if (bus.drain_req !== 1'b0) $display("FAIL rst_drain: got %0b expected 0", bus.drain_req); else passes++;
        checks++; if (bus.ctrl_trap !== 1'b0) $display("FAIL rst_trap: got %0b expected 0", bus.ctrl_trap); else passes++;
        checks++; if (bus.redirect_valid !== 1'b0) $display("FAIL rst_rvalid: got %0b expected 0", bus.redirect_valid); else passes++;
        checks++; if (bus.redirect_pc !== 32'h0) $display("FAIL rst_rpc: got 0x%0h expected 0x0", bus.redirect_pc); else passes++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b expected 1", bus.req_ready); else passes++;
    endtask

    task automatic test_exception();
        bus.mtvec = 32'h800;
        bus.exc_valid = 1'b1; bus.exc_code = 4'd2; bus.exc_pc = 32'h100;
        tick();
        bus.exc_valid = 1'b0;
        checks++; if (bus.drain_req !== 1'b1) $display("FAIL exc_drain: got %0b expected 1", bus.drain_req); else passes++;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL exc_ready_busy: got %0b expected 0", bus.req_ready); else passes++;
        tick(); tick();
        checks++; if (bus.drain_req !== 1'b1) $display("FAIL exc_drain_hold: got %0b expected 1", bus.drain_req); else passes++;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        checks++; if (bus.ctrl_trap !== 1'b1) $display("FAIL exc_trap: got %0b expected 1", bus.ctrl_trap); else passes++;
        checks++; if (bus.ctrl_mret !== 1'b0) $display("FAIL exc_mret: got %0b expected 0", bus.ctrl_mret); else passes++;
        chk("exc_info", {27'd0, bus.trap_info}, 32'h02);
        chk("exc_pc", bus.trap_pc, 32'h100);
        tick();
        checks++; if (bus.ctrl_trap !== 1'b0) $display("FAIL exc_trap_one_cycle: got %0b expected 0", bus.ctrl_trap); else passes++;
        checks++; if (bus.redirect_valid !== 1'b1) $display("FAIL exc_rvalid: got %0b expected 1", bus.redirect_valid); else passes++;
        chk("exc_rpc", bus.redirect_pc, 32'h800);
        tick(); tick();
        checks++; if (bus.redirect_valid !== 1'b1) $display("FAIL exc_rvalid_hold: got %0b expected 1", bus.redirect_valid); else passes++;
        chk("exc_rpc_hold", bus.redirect_pc, 32'h800);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        checks++; if (bus.redirect_valid !== 1'b0) $display("FAIL exc_rvalid_drop: got %0b expected 0", bus.redirect_valid); else passes++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL exc_ready_back: got %0b expected 1", bus.req_ready); else passes++;
    endtask

    task automatic test_irq();
        bus.mtvec = 32'h800; bus.irq_pc = 32'h3000;
        bus.ctrl_mxie = 3'b111; bus.ctrl_mie = 1'b1; bus.irq_raw = 3'b101;
        tick();
        chk("irq_mxip_early", {29'd0, bus.ctrl_mxip}, 32'h0);
        tick();
        chk("irq_mxip_sync", {29'd0, bus.ctrl_mxip}, 32'h5);
        checks++; if (bus.drain_req !== 1'b0) $display("FAIL irq_no_drain_yet: got %0b expected 0", bus.drain_req); else passes++;
        tick();
        checks++; if (bus.drain_req !== 1'b1) $display("FAIL irq_drain: got %0b expected 1", bus.drain_req); else passes++;
        // Line and enable drop mid-drain; the latched interrupt must still commit.
        bus.irq_raw = 3'b000; bus.ctrl_mie = 1'b0; bus.irq_pc = 32'h9999;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        checks++; if (bus.ctrl_trap !== 1'b1) $display("FAIL irq_trap: got %0b expected 1", bus.ctrl_trap); else passes++;
        chk("irq_info", {27'd0, bus.trap_info}, 32'h1B);
        chk("irq_pc", bus.trap_pc, 32'h3000);
        tick();
        chk("irq_rpc", bus.redirect_pc, 32'h800);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        tick();
        checks++; if (bus.drain_req !== 1'b0) $display("FAIL irq_no_retake: got %0b expected 0", bus.drain_req); else passes++;
        bus.ctrl_mxie = 3'b000;
    endtask

    task automatic test_mret();
        bus.mepc = 32'h240; bus.mret_valid = 1'b1;
        tick();
        bus.mret_valid = 1'b0;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        checks++; if (bus.ctrl_trap !== 1'b1) $display("FAIL mret_trap: got %0b expected 1", bus.ctrl_trap); else passes++;
        checks++; if (bus.ctrl_mret !== 1'b1) $display("FAIL mret_mret: got %0b expected 1", bus.ctrl_mret); else passes++;
        chk("mret_info", {27'd0, bus.trap_info}, 32'h0);
        tick();
        checks++; if (bus.ctrl_mret !== 1'b0) $display("FAIL mret_one_cycle: got %0b expected 0", bus.ctrl_mret); else passes++;
        chk("mret_rpc", bus.redirect_pc, 32'h240);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_irq_rpc;
`ifdef TRAP_CTRL_VECTORED_EN
        exp_irq_rpc = 32'h101C;
`else
        exp_irq_rpc = 32'h1000;
`endif
        bus.mtvec = 32'h1001; bus.irq_pc = 32'h4000;
        bus.ctrl_mie = 1'b0; bus.ctrl_mxie = 3'b100; bus.irq_raw = 3'b100;
        tick(); tick(); tick();
        bus.ctrl_mie = 1'b1;
        bus.exc_valid = 1'b1; bus.exc_code = 4'd5; bus.exc_pc = 32'h200;
        bus.mret_valid = 1'b1;
        tick();
        bus.exc_valid = 1'b0; bus.mret_valid = 1'b0;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        chk("b2b_exc_info", {27'd0, bus.trap_info}, 32'h05);
        chk("b2b_exc_pc", bus.trap_pc, 32'h200);
        checks++; if (bus.ctrl_mret !== 1'b0) $display("FAIL b2b_exc_not_mret: got %0b expected 0", bus.ctrl_mret); else passes++;
        tick();
        chk("b2b_exc_rpc", bus.redirect_pc, 32'h1000);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        tick();
        checks++; if (bus.drain_req !== 1'b1) $display("FAIL b2b_irq_drain: got %0b expected 1", bus.drain_req); else passes++;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0; bus.ctrl_mie = 1'b0;
        chk("b2b_irq_info", {27'd0, bus.trap_info}, 32'h17);
        chk("b2b_irq_pc", bus.trap_pc, 32'h4000);
        tick();
        chk("b2b_irq_rpc", bus.redirect_pc, exp_irq_rpc);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        bus.irq_raw = 3'b000; bus.ctrl_mxie = 3'b000;
    endtask

    task automatic test_vectored();
        logic [31:0] exp_rpc;
        bit          seen;
`ifdef TRAP_CTRL_VECTORED_EN
        exp_rpc = 32'h100C;
`else
        exp_rpc = 32'h1000;
`endif
        bus.mtvec = 32'h1001; bus.irq_pc = 32'h5000;
        bus.ctrl_mxie = 3'b010; bus.irq_raw = 3'b010; bus.ctrl_mie = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.drain_req === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) $display("FAIL vec_drain_timeout: got %0b expected 1", seen); else passes++;
        bus.ctrl_mie = 1'b0; bus.irq_raw = 3'b000;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        chk("vec_info", {27'd0, bus.trap_info}, 32'h13);
        tick();
        chk("vec_rpc", bus.redirect_pc, exp_rpc);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0; bus.ctrl_mxie = 3'b000;
    endtask

    task automatic test_reset_mid_drain();
        bit saw_trap;
        bit saw_drain;
        bus.mtvec = 32'h800; bus.ctrl_mie = 1'b0; bus.irq_raw = 3'b111;
        bus.exc_valid = 1'b1; bus.exc_code = 4'd1; bus.exc_pc = 32'h500;
        tick();
        bus.exc_valid = 1'b0;
        tick(); tick();
        checks++; if (bus.drain_req !== 1'b1) $display("FAIL rd_drain: got %0b expected 1", bus.drain_req); else passes++;
        chk("rd_mxip_before", {29'd0, bus.ctrl_mxip}, 32'h7);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.drain_req !== 1'b0) $display("FAIL rd_drain_clr: got %0b expected 0", bus.drain_req); else passes++;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rd_ready_clr: got %0b expected 0", bus.req_ready); else passes++;
        chk("rd_mxip_clr", {29'd0, bus.ctrl_mxip}, 32'h0);
        bus.irq_raw = 3'b000; bus.drain_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        saw_trap = 1'b0; saw_drain = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ctrl_trap !== 1'b0) saw_trap = 1'b1;
            if (bus.drain_req !== 1'b0) saw_drain = 1'b1;
        end
        checks++; if (saw_trap !== 1'b0) $display("FAIL rd_no_trap: got %0b expected 0", saw_trap); else passes++;
        checks++; if (saw_drain !== 1'b0) $display("FAIL rd_no_drain: got %0b expected 0", saw_drain); else passes++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rd_ready_after: got %0b expected 1", bus.req_ready); else passes++;
        bus.drain_ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_exception();
        test_irq();
        test_mret();
        test_back_to_back();
        test_vectored();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, flops in each interrupt-line synchronizer (legal 2..4).
REQ-002 SHALL have port: ctrl_clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: ctrl_reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: irq_raw  in  3  asynchronous pending lines: [0] external, [1] software, [2] timer.
REQ-005 SHALL have ports: ctrl_mie  in  1  global enable; ctrl_mxie  in  3  per-source enables, same bit order as irq_raw.
REQ-006 SHALL have ports: mtvec  in  32  trap vector CSR; mepc  in  32  exception PC CSR.
REQ-007 SHALL have ports: exc_valid  in  1, exc_code  in  4, exc_pc  in  32  synchronous exception request.
REQ-008 SHALL have ports: mret_valid  in  1  mret request; irq_pc  in  32  PC of next unissued instruction.
REQ-009 SHALL have port: req_ready  out  1  exc/mret request accepted this cycle.
REQ-010 SHALL have ports: drain_req  out  1; drain_ack  in  1  pipeline empty, no CSR access in flight.
REQ-011 SHALL have ports: ctrl_mxip  out  3  synchronized pending lines to the CSR file.
REQ-012 SHALL have ports: ctrl_trap  out  1; ctrl_mret  out  1; trap_pc  out  32; trap_info  out  5  ({is_irq, code[3:0]}).
REQ-013 SHALL have ports: redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1.

Function
REQ-014 ctrl_mxip SHALL equal irq_raw delayed through SYNC_STAGES flops; no other gating.
REQ-015 Pending interrupt SHALL mean ctrl_mie & |(ctrl_mxip & ctrl_mxie); priority external (11) > software (3) > timer (7).
REQ-016 FSM states SHALL be IDLE, DRAIN, COMMIT, REDIRECT.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, event priority SHALL be exception > mret > pending interrupt; the winner, cause, and saved PC (exc_pc, or irq_pc for interrupts) SHALL be latched and the FSM SHALL move to DRAIN next cycle.
REQ-019 Losing simultaneous events SHALL NOT be latched; pipeline re-presents exc/mret, and interrupts are re-evaluated on return to IDLE.
REQ-020 drain_req SHALL be 1 exactly while in DRAIN; drain_ack outside DRAIN SHALL be ignored.
REQ-021 Once latched, an interrupt SHALL be committed even if its line or enable drops during DRAIN.
REQ-022 DRAIN SHALL go to COMMIT on the cycle drain_ack is sampled high.
REQ-023 COMMIT SHALL last exactly one cycle: ctrl_trap=1; ctrl_mret=1 for mret only; trap_pc/trap_info = latched values (trap_info=0 for mret).
REQ-024 Exception trap_info SHALL be {1'b0, exc_code}; interrupt trap_info SHALL be {1'b1, cause}.
REQ-025 In COMMIT, redirect_pc SHALL be registered from mepc for mret and from {mtvec[31:2],2'b00} otherwise (see REQ-030).
REQ-026 REDIRECT SHALL hold redirect_valid=1 and stable redirect_pc until redirect_ready is sampled high, then return to IDLE.
REQ-027 ctrl_trap, ctrl_mret, drain_req, and redirect_valid SHALL all be 0 outside their states.

Reset
REQ-028 On ctrl_reset_n low, asynchronously: FSM=IDLE; all synchronizer flops, latched event, and all outputs SHALL be 0, including mid-DRAIN or mid-REDIRECT; no partial trap SHALL be emitted after release.

Configuration
REQ-029 Macro TRAP_CTRL_VECTORED_EN SHALL select vectored-mode support.
REQ-030 With TRAP_CTRL_VECTORED_EN defined, mtvec[1:0]==1, and an interrupt trap, redirect_pc SHALL be {mtvec[31:2],2'b00} + 4*cause; without the macro, mtvec[1:0] SHALL be ignored and the base SHALL always be used.

Structure
REQ-031 Package trap_pkg SHALL hold the FSM state enum, the cause constants (MEI=11, MSI=3, MTI=7), and the trap_info struct.
REQ-032 Sub-module irq_sync SHALL be a parameterized SYNC_STAGES-deep, 3-bit synchronizer with async active-low clear.

Verification
REQ-033 exc_valid=1, exc_code=2, exc_pc=0x100, drain_ack after 3 cycles, mtvec=0x800 -> one-cycle ctrl_trap, trap_info=0x02, trap_pc=0x100, then redirect_pc=0x800 held until redirect_ready.
REQ-034 irq_raw=3'b101, mie=1, mxie=3'b111 -> ctrl_mxip high after SYNC_STAGES cycles; trap_info=0x1B (external wins).
REQ-035 mret_valid with mepc=0x240 -> ctrl_mret=ctrl_trap=1 for one cycle, redirect_pc=0x240.
REQ-036 exc_valid and a pending timer irq in the same cycle -> exception committed first; after redirect handshake the timer trap is taken (trap_info=0x17) if still enabled.
REQ-037 Vectored build, mtvec=0x1001, software irq -> redirect_pc=0x100C; non-vectored build -> 0x1000.
REQ-038 ctrl_reset_n pulsed low during DRAIN -> all outputs 0 immediately, req_ready=1 after release, no ctrl_trap pulse.
